// File: rtl/grf_writeback.sv
// Write-back stage: decodes the W instruction, commits to the 32x32 GPR file,
// serves two D-stage read ports with same-cycle bypass, and traces commits.
module grf_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_instr,
    input  logic [31:0] W_pc,
    input  logic [31:0] W_alu,
    input  logic [31:0] W_dm,
    input  logic [4:0]  D_ra1,
    input  logic [4:0]  D_ra2,
    output logic [31:0] D_rd1,
    output logic [31:0] D_rd2,
    output logic [4:0]  W_wa,
    output logic [31:0] W_wd,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [4:0]  commit_reg,
    output logic [31:0] commit_data,
    output logic [31:0] retired
);

    logic [31:0] regs [32];
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        we;

    assign op    = W_instr[31:26];
    assign funct = W_instr[5:0];

    always_comb begin
        dest = '0;
        data = '0;
        // an all-zero word is a bubble even though it decodes as sll
        if (W_instr != '0) begin
            case (op)
                6'h00: begin
                    if (funct == 6'h21 || funct == 6'h23) begin
                        dest = W_instr[15:11];
                        data = W_alu;
                    end
                end
                6'h0d, 6'h0f: begin
                    dest = W_instr[20:16];
                    data = W_alu;
                end
                6'h23: begin
                    dest = W_instr[20:16];
                    data = W_dm;
                end
                6'h03: begin
                    dest = 5'd31;
                    data = W_pc + 32'd8;
                end
                default: begin
                    dest = '0;
                    data = '0;
                end
            endcase
        end
    end

    assign we   = (dest != '0);
    assign W_wa = dest;
    assign W_wd = we ? data : '0;

    function automatic logic [31:0] read_port(input logic [4:0] ra);
        logic [31:0] v;
        if (ra == '0)
            v = '0;
        else if (we && ra == W_wa)
            v = W_wd;
        else
            v = regs[ra];
        return v;
    endfunction

    always_comb begin
        D_rd1 = read_port(D_ra1);
        D_rd2 = read_port(D_ra2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_reg   <= '0;
            commit_data  <= '0;
            retired      <= '0;
        end else begin
            if (we)
                regs[W_wa] <= W_wd;
            commit_valid <= we;
            commit_pc    <= we ? W_pc : '0;
            commit_reg   <= W_wa;
            commit_data  <= W_wd;
            if (W_instr != '0)
                retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_grf_writeback.sv
// Randomized scoreboard bench for grf_writeback against an array-based
// architectural model of the MIPS register file.
module tb_grf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, alu, dm;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2, wd, c_pc, c_data, ret;
    logic [4:0]  wa, c_reg;
    logic        c_valid;

    always #5 clk = ~clk;

    grf_writeback dut (
        .clk(clk), .reset(rst),
        .W_instr(instr), .W_pc(pc), .W_alu(alu), .W_dm(dm),
        .D_ra1(ra1), .D_ra2(ra2), .D_rd1(rd1), .D_rd2(rd2),
        .W_wa(wa), .W_wd(wd),
        .commit_valid(c_valid), .commit_pc(c_pc),
        .commit_reg(c_reg), .commit_data(c_data), .retired(ret)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 0;
    logic [31:0] mregs [32];
    logic [31:0] m_retired;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // architectural meaning of one W-stage instruction
    task automatic arch(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] m,
                        output logic [4:0] d, output logic [31:0] v);
        d = 0;
        v = 0;
        if (i != 0) begin
            if (i[31:26] == 6'h00 && (i[5:0] == 6'h21 || i[5:0] == 6'h23)) begin
                d = i[15:11]; v = a;
            end else if (i[31:26] == 6'h0d || i[31:26] == 6'h0f) begin
                d = i[20:16]; v = a;
            end else if (i[31:26] == 6'h23) begin
                d = i[20:16]; v = m;
            end else if (i[31:26] == 6'h03) begin
                d = 31; v = p + 8;
            end
        end
        if (d == 0) v = 0;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] ra,
                                          input logic [4:0] d,
                                          input logic [31:0] v);
        if (ra == 0) return 0;
        if (d != 0 && ra == d) return v;
        return mregs[ra];
    endfunction

    task automatic cycle(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] m,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic rs);
        logic [4:0]  d;
        logic [31:0] v;
        @(negedge clk);
        instr = i; pc = p; alu = a; dm = m;
        ra1 = r1; ra2 = r2; rst = rs;
        #1;
        arch(i, p, a, m, d, v);
        chk("W_wa", {27'd0, wa}, {27'd0, d});
        chk("W_wd", wd, v);
        chk("D_rd1", rd1, mread(r1, d, v));
        chk("D_rd2", rd2, mread(r2, d, v));
        if (!rs) begin
            for (int k = 0; k < 32; k++) mregs[k] = 0;
            m_retired = 0;
        end else begin
            if (d != 0) begin
                mregs[d] = v;
                sb.push_back('{pc: p, r: d, d: v});
            end
            if (i != 0) m_retired = m_retired + 1;
        end
        mon_en = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("retired", ret, m_retired);
            if (c_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("commit_spurious", {31'd0, c_valid}, 32'd0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("commit_pc", c_pc, e.pc);
                    chk("commit_reg", {27'd0, c_reg}, {27'd0, e.r});
                    chk("commit_data", c_data, e.d);
                end
            end else begin
                chk("commit_idle", {c_pc ^ c_data, 27'd0} | {27'd0, c_reg},
                    32'd0);
                chk("commit_missing", sb.size(), 0);
            end
        end
    end

    function automatic logic [31:0] rnd_instr(input int kind);
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case (kind)
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            2:  return {6'h0d, rs, rt, imm};
            3:  return {6'h0f, 5'd0, rt, imm};
            4:  return {6'h23, rs, rt, imm};
            5:  return {6'h03, 26'($urandom)};
            6:  return {6'h2b, rs, rt, imm};
            7:  return {6'h04, rs, rt, imm};
            8:  return {6'h02, 26'($urandom)};
            9:  return {6'h00, rs, 15'd0, 6'h08};
            10: return 32'd0;
            11: return {6'h3f, 26'($urandom)};
            default: return {6'h00, 5'd0, rt, rd | 5'd1, 5'd3, 6'h00};
        endcase
    endfunction

    initial begin
        m_retired = 0;
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        instr = 0; pc = 0; alu = 0; dm = 0; ra1 = 0; ra2 = 0; rst = 0;
        // reset held with an ori in flight, then released
        cycle(32'h34010005, 32'h100, 5, 0, 1, 2, 0);
        cycle(32'h34010005, 32'h100, 5, 0, 1, 2, 0);
        cycle(32'h34010005, 32'h104, 5, 0, 1, 2, 1);
        cycle(32'h0, 32'h108, 0, 0, 1, 2, 1);
        // ori bypass
        cycle(32'h34010009, 32'h200, 9, 0, 1, 1, 1);
        cycle(32'h0, 32'h204, 0, 0, 1, 0, 1);
        // addu into $0
        cycle(32'h00210021, 32'h300, 32'hDEADBEEF, 0, 0, 1, 1);
        // jal
        cycle(32'h0C000010, 32'h3004, 0, 0, 1, 31, 1);
        cycle(32'h0, 32'h3008, 0, 0, 31, 31, 1);
        // lw then sw with the same rt
        cycle(32'h8C020040, 32'h400, 32'h40, 32'h12345678, 2, 0, 1);
        cycle(32'hAC020040, 32'h404, 32'h40, 32'h55555555, 2, 2, 1);
        // write $3 then reset on a lui $3
        cycle(32'h34030007, 32'h500, 7, 0, 3, 0, 1);
        cycle(32'h3C030001, 32'h504, 32'h10000, 0, 3, 3, 0);
        cycle(32'h0, 32'h508, 0, 0, 3, 1, 1);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(rnd_instr($urandom_range(0, 12)), $urandom, $urandom,
                  $urandom, 5'($urandom_range(0, 8)),
                  5'($urandom_range(0, 8)), ($urandom_range(0, 39) != 0));
        end
        cycle(32'h0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_writeback.md
# grf_writeback

Write-back stage and general register file of the five-stage MIPS pipeline; the consuming end of the M→W pipeline register. Decodes the W-stage instruction, selects the write-back value (ALU result, DM load data, or PC+8), commits it to a 32×32 register file, and serves the D stage's two read ports with same-cycle W→D bypass. Also exports the W-stage destination/data for the hazard unit, a registered commit trace, and a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- W_instr  in  32  W-stage instruction (0 = bubble/nop)
- W_pc  in  32  W-stage PC
- W_alu  in  32  ALU result carried to W
- W_dm  in  32  DM load data carried to W
- D_ra1  in  5  D-stage read address 1 (rs)
- D_ra2  in  5  D-stage read address 2 (rt)
- D_rd1  out  32  read data 1, combinational
- D_rd2  out  32  read data 2, combinational
- W_wa  out  5  W-stage write address after decode (0 if no write), combinational
- W_wd  out  32  W-stage write data, combinational
- commit_valid  out  1  registered: a register write committed on the previous edge
- commit_pc  out  32  registered PC of that write
- commit_reg  out  5  registered destination
- commit_data  out  32  registered data
- retired  out  32  registered count of non-bubble instructions retired

## Operation
- Decode (op = W_instr[31:26], funct = [5:0]):
  - op 0x00, funct 0x21 (addu) / 0x23 (subu): dest rd [15:11], data W_alu.
  - op 0x0d (ori), 0x0f (lui): dest rt [20:16], data W_alu.
  - op 0x23 (lw): dest rt, data W_dm.
  - op 0x03 (jal): dest 31, data W_pc + 8 (32-bit wrap).
  - everything else (sw, beq, j, jr, nop, unknown): no write; W_wa = 0, W_wd = 0.
- W_instr == 0 is always a bubble, even though op/funct decode to sll.
- Write enable = (W_wa != 0). Register $0 is never written and always reads 0.
- Read: D_rdN = 0 if D_raN == 0; else W_wd if D_raN == W_wa (bypass); else regs[D_raN].
- Commit trace: each edge with reset high loads commit_valid ← (W_wa != 0), commit_pc ← W_pc, commit_reg ← W_wa, commit_data ← W_wd. Non-writing cycles load commit_valid = 0 with the other fields = 0.
- retired increments by 1 on each edge with reset high and W_instr != 0, including non-writing instructions. Wraps 0xFFFFFFFF → 0.

## Timing
- Reset (reset == 0 at posedge): all 32 registers, commit_valid/pc/reg/data, and retired ← 0. Any write presented in that cycle is dropped. Reset asserted mid-stream takes priority over every pending write.
- Register write lands at the posedge where W_instr is present. Zero-cycle visibility to D via bypass in the same cycle; array visible from the next cycle.
- commit_* and retired lag the W-stage instruction by exactly one cycle.
- D_rd*, W_wa, and W_wd are purely combinational from the current inputs and the register array, with no clock latency.
- Both read ports addressing the written register get the bypassed value at the same time.
- No stall input. W_REG holds its contents, so a held instruction re-commits and recounts each cycle. This is intended.

## Test plan
- Reset: hold reset=0 for 2 cycles with W_instr = ori $1,$0,5 and W_alu = 5, then release -> all D_rd* = 0, retired = 0, commit_valid = 0. The first cycle after release writes $1 = 5.
- ori bypass: W_instr = 0x34010005 (ori $1,$0,5), W_alu = 5, D_ra1 = 1 -> same cycle D_rd1 = 5, W_wa = 1. Next cycle (bubble) D_rd1 = 5 from the array, and commit = {1, pc, 1, 5}.
- $0 guard: addu with rd = 0, W_alu = 0xDEADBEEF -> W_wa = 0, commit_valid = 0 next cycle, D_rd1 for ra = 0 stays 0, retired increments.
- jal: W_instr = 0x0C000010, W_pc = 0x00003004 -> $31 = 0x0000300C. D_ra2 = 31 reads 0x0000300C in the same cycle.
- lw vs sw: lw $2 with W_dm = 0x12345678 and W_alu = 0x40 -> $2 = 0x12345678. The following sw with the same rt -> no write, $2 unchanged, retired +1.
- Reset mid-stream: write $3 = 7, then assert reset on a cycle carrying lui $3 -> $3 = 0 after the edge, retired = 0, commit_valid = 0.
